// File: rtl/if_fetch_unit_if.sv
// Instruction-memory handshake between the fetch unit and the instruction memory.
//   imem_req  : fetch unit -> memory, request pending
//   imem_addr : fetch unit -> memory, word address, stable while imem_req=1
//   imem_ack  : memory -> fetch unit, one-cycle acknowledge
//   imem_data : memory -> fetch unit, instruction word, valid in the imem_ack cycle
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with IF/ID output register and a one-entry skid buffer.
// Ports:
//   clk            : sole clock, rising edge
//   rst            : asynchronous active-low reset
//   freeze         : decode hazard, hold IF/ID outputs
//   branch_taken   : redirect fetch to branch_address and flush IF/ID
//   branch_address : redirect target, bits [1:0] ignored
//   imem           : instruction-memory handshake (master side)
//   pc             : fetch address + 4 of the held instruction
//   instruction    : held instruction word
//   valid          : pc/instruction hold a real fetched instruction
//   stall_count    : only with IF_FETCH_STALL_COUNT_EN defined; saturating count of
//                    cycles with imem_req=1 and imem_ack=0
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | request to imem_addr outstanding
// HOLD  | fetched word parked in skid buffer while decode is frozen
module if_fetch_unit (
  input  logic           clk,
  input  logic           rst,
  input  logic           freeze,
  input  logic           branch_taken,
  input  logic [31:0]    branch_address,
  if_fetch_unit_if.master imem,
  output logic [31:0]    pc,
  output logic [31:0]    instruction,
  output logic           valid
`ifdef IF_FETCH_STALL_COUNT_EN
  ,
  output logic [15:0]    stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_inc;
  logic [31:0] branch_target;
  logic [31:0] req_addr;     // address of a request being drained after a redirect
  logic        discard;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  assign fetch_pc_inc  = fetch_pc + 32'd4;
  assign branch_target = branch_address & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (!branch_taken && imem.imem_ack && !discard && freeze) state_nxt = HOLD;
        else                                                      state_nxt = REQ;
      end
      HOLD: begin
        if (branch_taken || !freeze) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While a redirected request drains, the bus keeps showing the old address.
  always_comb begin
    imem.imem_req  = (state == REQ);
    imem.imem_addr = discard ? req_addr : fetch_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= 32'd0;
      req_addr    <= 32'd0;
      discard     <= 1'b0;
      pc          <= 32'd0;
      instruction <= 32'd0;
      valid       <= 1'b0;
      skid_instr  <= 32'd0;
      skid_pc     <= 32'd0;
    end else if (branch_taken) begin
      instruction <= 32'd0;
      valid       <= 1'b0;
      fetch_pc    <= branch_target;
      skid_instr  <= 32'd0;
      skid_pc     <= 32'd0;
      if (state == REQ && !imem.imem_ack) begin
        // Keep the original address if a redirect is already draining.
        if (!discard) req_addr <= fetch_pc;
        discard <= 1'b1;
      end else begin
        discard <= 1'b0;
      end
    end else begin
      case (state)
        REQ: begin
          if (imem.imem_ack && !discard) begin
            fetch_pc <= fetch_pc_inc;
            if (!freeze) begin
              instruction <= imem.imem_data;
              pc          <= fetch_pc_inc;
              valid       <= 1'b1;
            end else begin
              skid_instr <= imem.imem_data;
              skid_pc    <= fetch_pc_inc;
            end
          end else begin
            if (imem.imem_ack) discard <= 1'b0;
            if (!freeze)       valid   <= 1'b0;
          end
        end
        HOLD: begin
          if (!freeze) begin
            instruction <= skid_instr;
            pc          <= skid_pc;
            valid       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IF_FETCH_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                  stall_count <= 16'd0;
    else if (imem.imem_req && !imem.imem_ack && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = 32'd0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;
`ifdef IF_FETCH_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  if_fetch_unit_if imem();

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem           (imem),
    .pc             (pc),
    .instruction    (instruction),
    .valid          (valid)
`ifdef IF_FETCH_STALL_COUNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back({p, i});
  endtask

  task automatic drive(input logic ack, input logic [31:0] data, input logic frz,
                       input logic br, input logic [31:0] badr);
    imem.imem_ack  = ack;
    imem.imem_data = data;
    freeze         = frz;
    branch_taken   = br;
    branch_address = badr;
  endtask

  // Monitor: every newly presented instruction must match the next expected fetch.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = 32'd0;
  logic [31:0] prev_instr = 32'd0;
  always @(negedge clk) begin
    if (rst && valid && (!prev_valid || pc !== prev_pc || instruction !== prev_instr)) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_output: got pc=%h instr=%h expected none", pc, instruction);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_pc", pc, e[63:32]);
        check("sb_instr", instruction, e[31:0]);
      end
    end
    prev_valid = rst && valid;
    prev_pc    = pc;
    prev_instr = instruction;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem.imem_req}, 32'd0);
    check("rst_addr", imem.imem_addr, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b1;

    // Sequential fetch with an ack every request cycle
    @(negedge clk);
    check("seq_req0", {31'd0, imem.imem_req}, 32'd1);
    check("seq_addr0", imem.imem_addr, 32'h0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0); push(32'h4, 32'h0);
    @(negedge clk);
    check("seq_addr4", imem.imem_addr, 32'h4);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0); push(32'h8, 32'h4);
    @(negedge clk);
    check("seq_addr8", imem.imem_addr, 32'h8);
    check("seq_valid", {31'd0, valid}, 32'd1);

    // Ack at 8 while frozen for three cycles
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'd0); push(32'hC, 32'h8);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("hold_req", {31'd0, imem.imem_req}, 32'd0);
      check("hold_pc", pc, 32'h8);
      check("hold_instr", instruction, 32'h4);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    end
    @(negedge clk);
    check("hold_pc3", pc, 32'h8);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check("unhold_pc", pc, 32'hC);
    check("unhold_req", {31'd0, imem.imem_req}, 32'd1);
    check("unhold_addr", imem.imem_addr, 32'hC);

    // Bubble: no ack, no freeze
    @(negedge clk);
    check("bubble_valid", {31'd0, valid}, 32'd0);
    check("bubble_pc", pc, 32'hC);
    check("bubble_instr", instruction, 32'h8);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 32'd0); push(32'h10, 32'hC);
    @(negedge clk);
    check("addr_10", imem.imem_addr, 32'h10);

    // Redirect while request to 0x10 outstanding; low address bits ignored
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h103);
    @(negedge clk);
    check("br_valid", {31'd0, valid}, 32'd0);
    check("br_instr", instruction, 32'd0);
    check("br_pc", pc, 32'h10);
    check("br_held_addr", imem.imem_addr, 32'h10);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check("br_held_addr2", imem.imem_addr, 32'h10);
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check("br_discard_valid", {31'd0, valid}, 32'd0);
    check("br_new_addr", imem.imem_addr, 32'h100);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0); push(32'h104, 32'h100);
    @(negedge clk);
    check("br_pc104", pc, 32'h104);

    // Redirect with freeze in the ack cycle
    drive(1'b1, 32'hBAD, 1'b1, 1'b1, 32'h200);
    @(negedge clk);
    check("brf_instr", instruction, 32'd0);
    check("brf_valid", {31'd0, valid}, 32'd0);
    check("brf_pc", pc, 32'h104);
    check("brf_addr", imem.imem_addr, 32'h200);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'd0); push(32'h204, 32'h200);
    @(negedge clk);
    check("brf_next_addr", imem.imem_addr, 32'h204);

    // Redirect in HOLD, then wrap at the top of the address space
    drive(1'b1, 32'h204, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("hbr_req", {31'd0, imem.imem_req}, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    check("hbr_req2", {31'd0, imem.imem_req}, 32'd1);
    check("hbr_addr", imem.imem_addr, 32'hFFFF_FFFC);
    check("hbr_valid", {31'd0, valid}, 32'd0);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0); push(32'h0, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc", pc, 32'h0);
    check("wrap_addr", imem.imem_addr, 32'h0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Reset during an outstanding request
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_req", {31'd0, imem.imem_req}, 32'd0);
    check("mrst_addr", imem.imem_addr, 32'd0);
    check("mrst_pc", pc, 32'd0);
    check("mrst_instr", instruction, 32'd0);
    check("mrst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h55, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check("mrst_ack_ignored", {31'd0, valid}, 32'd0);
    check("mrst_req1", {31'd0, imem.imem_req}, 32'd1);
    check("mrst_addr0", imem.imem_addr, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
`ifdef IF_FETCH_STALL_COUNT_EN
    check("stall_5", {16'd0, stall_count}, 32'd5);
    rst = 1'b0;
    #1;
    check("stall_rst", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
`endif
    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port freeze, input, 1, decode-stage hazard; hold IF/ID outputs.
REQ-004 SHALL have port branch_taken, input, 1, redirect fetch and flush IF/ID.
REQ-005 SHALL have port branch_address, input, 32, redirect target (word-aligned).
REQ-006 SHALL have port imem_req, output, 1, instruction-memory request.
REQ-007 SHALL have port imem_addr, output, 32, fetch address, stable while imem_req=1.
REQ-008 SHALL have port imem_ack, input, 1, one-cycle acknowledge; imem_data valid that cycle.
REQ-009 SHALL have port imem_data, input, 32, fetched instruction word.
REQ-010 SHALL have port pc, output, 32, fetch address + 4 of the held instruction.
REQ-011 SHALL have port instruction, output, 32, held instruction word to decode.
REQ-012 SHALL have port valid, output, 1, instruction/pc hold a real fetched instruction.

Function
REQ-013 SHALL keep a 32-bit fetch_pc; states IDLE, REQ, HOLD.
REQ-014 IDLE: imem_req=0; next state REQ unconditionally (one cycle after reset release).
REQ-015 REQ: imem_req=1, imem_addr=fetch_pc; imem_req and imem_addr SHALL stay constant until imem_ack.
REQ-016 REQ with imem_ack, no discard, freeze=0: load instruction=imem_data, pc=fetch_pc+4, valid=1; fetch_pc+=4; stay REQ.
REQ-017 REQ with imem_ack, no discard, freeze=1: capture imem_data and fetch_pc+4 in skid buffer; fetch_pc+=4; go HOLD; IF/ID outputs unchanged.
REQ-018 REQ without imem_ack, freeze=0: valid SHALL go 0 (bubble), instruction/pc unchanged; with freeze=1 outputs hold.
REQ-019 HOLD: imem_req=0; when freeze=0, move skid buffer to outputs with valid=1, go REQ.
REQ-020 freeze=1 SHALL leave pc, instruction, valid unchanged, except per REQ-021.
REQ-021 branch_taken=1 SHALL (priority over freeze and ack) next cycle set instruction=0, valid=0, pc unchanged, fetch_pc=branch_address, skid buffer emptied.
REQ-022 branch_taken in REQ with request outstanding (no ack same cycle): request SHALL be held to its ack, returned data discarded via discard flag, then new request issued to branch_address.
REQ-023 branch_taken in the cycle of imem_ack: that data SHALL be discarded; next state REQ at branch_address.
REQ-024 branch_taken in HOLD: buffer discarded, next state REQ.
REQ-025 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-026 Branch_address bits [1:0] SHALL be forced to 0.

Reset
REQ-027 rst=0 SHALL asynchronously set state=IDLE, fetch_pc=0, pc=0, instruction=0, valid=0, imem_req=0, imem_addr=0, skid buffer empty, discard=0.
REQ-028 Reset mid-transaction SHALL drop imem_req immediately; a later imem_ack for the aborted request is ignored (no request pending).

Configuration
REQ-029 Macro IF_FETCH_STALL_COUNT_EN defined: add output stall_count, 16 bits, incrementing each cycle imem_req=1 and imem_ack=0, saturating at 16'hFFFF, cleared by reset.
REQ-030 Macro undefined: no stall_count port, no counter logic; all other behaviour identical.

Verification
REQ-031 Reset release, imem_ack every REQ cycle with data=addr: addresses 0,4,8; outputs (pc,instruction) = (4,0),(8,4),(12,8), valid=1.
REQ-032 ack at address 8 while freeze=1 for 3 cycles: outputs hold (8,4); HOLD with imem_req=0; freeze drop -> (12,8) next cycle, then request 12.
REQ-033 branch_taken with branch_address=0x100 while request to 0x10 unacked, ack 2 cycles later: 0x10 data discarded, valid=0, next imem_addr=0x100, then pc=0x104.
REQ-034 branch_taken with freeze=1: instruction=0, valid=0 next cycle; fetch resumes at target.
REQ-035 fetch_pc=0xFFFFFFFC acked: pc=0, next imem_addr=0.
REQ-036 rst low while imem_req=1: imem_req=0 same cycle, all outputs 0; with IF_FETCH_STALL_COUNT_EN, 5 unacked cycles -> stall_count=5, reset -> 0.
